// File: rtl/stopwatch_lap_timer.sv
// Stopwatch core: prescaled one-second tick, MM:SS up/down counting with preload,
// run/pause/done control and a show-ahead lap-capture FIFO.
module stopwatch_lap_timer #(
    parameter int TICK_DIV  = 1,
    parameter int MAX_MIN   = 99,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           reset,
    input  logic                           mode_down,
    input  logic                           load,
    input  logic [7:0]                     load_min,
    input  logic [5:0]                     load_sec,
    input  logic                           lap,
    input  logic                           lap_rd,
    output logic [7:0]                     minutes,
    output logic [5:0]                     seconds,
    output logic [1:0]                     status,
    output logic                           done,
    output logic [7:0]                     lap_min,
    output logic [5:0]                     lap_sec,
    output logic                           lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_ovf
);

    localparam int CW  = $clog2(LAP_DEPTH + 1);
    localparam int PW  = $clog2(LAP_DEPTH);
    localparam int PRW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRW-1:0] TICK_LAST = PRW'(TICK_DIV - 1);
    localparam logic [7:0]     MAX_MIN_V = 8'(MAX_MIN);
    localparam logic [CW-1:0]  FULL      = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic            mode_down_q, mode_down_d;
    logic [7:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [PRW-1:0]  presc_q, presc_d;
    logic            done_q, done_d;
    logic [13:0]     mem_q [LAP_DEPTH];
    logic [13:0]     mem_d [LAP_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            tick, push, push_ok, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_down_q <= 1'b0;
            min_q       <= '0;
            sec_q       <= '0;
            presc_q     <= '0;
            done_q      <= 1'b0;
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_down_q <= mode_down_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            done_q      <= done_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_down_d = mode_down_q;
        min_d       = min_q;
        sec_d       = sec_q;
        presc_d     = presc_q;
        done_d      = 1'b0;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        tick        = (presc_q == TICK_LAST);
        push        = lap && ((state_q == RUNNING) || (state_q == PAUSED));
        pop         = lap_rd && (count_q != '0);
        push_ok     = push && ((count_q != FULL) || pop);

        if (reset) begin
            state_d     = IDLE;
            mode_down_d = 1'b0;
            min_d       = '0;
            sec_d       = '0;
            presc_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (load) begin
                        min_d = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
                        sec_d = (load_sec > 6'd59) ? 6'd59 : load_sec;
                    end
                    // A count-down from 00:00 would finish instantly, so it never starts.
                    if (start && !stop && !(mode_down && (min_q == '0) && (sec_q == '0))) begin
                        state_d     = RUNNING;
                        mode_down_d = mode_down;
                    end
                end
                RUNNING: begin
                    if (stop) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        if (!mode_down_q) begin
                            if (sec_q == 6'd59) begin
                                sec_d = '0;
                                min_d = (min_q == MAX_MIN_V) ? 8'd0 : min_q + 8'd1;
                            end else begin
                                sec_d = sec_q + 6'd1;
                            end
                        end else if ((min_q == '0) && (sec_q <= 6'd1)) begin
                            sec_d   = '0;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (sec_q == '0) begin
                            sec_d = 6'd59;
                            min_d = min_q - 8'd1;
                        end else begin
                            sec_d = sec_q - 6'd1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start && !stop) begin
                        state_d = RUNNING;
                    end
                end
                DONE: begin
                    presc_d = '0;
                end
            endcase

            // A pop frees the slot, so push+pop on a full FIFO is not an overflow.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                mem_d[wr_ptr_q] = {min_q, sec_q};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end else if (push) begin
                ovf_d = 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign status    = state_q;
    assign done      = done_q;
    assign lap_valid = (count_q != '0);
    assign lap_min   = lap_valid ? mem_q[rd_ptr_q][13:6] : 8'd0;
    assign lap_sec   = lap_valid ? mem_q[rd_ptr_q][5:0] : 6'd0;
    assign lap_count = count_q;
    assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Bench for stopwatch_lap_timer: two instances (TICK_DIV 1 and 4) share stimulus and are
// checked every cycle against a seconds-count reference model, plus directed scenarios.
module tb_stopwatch_lap_timer;

    localparam int MAX_MIN = 99;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, reset, mode_down, load, lap, lap_rd;
    logic [7:0] load_min;
    logic [5:0] load_sec;

    logic [7:0] minutes1, lap_min1, minutes4, lap_min4;
    logic [5:0] seconds1, lap_sec1, seconds4, lap_sec4;
    logic [1:0] status1, status4;
    logic [2:0] lap_count1, lap_count4;
    logic       done1, lap_valid1, lap_ovf1, done4, lap_valid4, lap_ovf4;

    int checks = 0;
    int errors = 0;
    int done1_pulses = 0;

    // Reference model: time kept as a plain seconds total, FIFO as a shifting list.
    int td [2] = '{1, 4};
    int m_st [2];
    int m_t [2];
    int m_pr [2];
    int m_mode [2];
    int m_done [2];
    int m_cnt [2];
    int m_ovf [2];
    int m_fifo [2][DEPTH];

    stopwatch_lap_timer #(.TICK_DIV(1), .MAX_MIN(MAX_MIN), .LAP_DEPTH(DEPTH)) u_td1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
        .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
        .lap(lap), .lap_rd(lap_rd), .minutes(minutes1), .seconds(seconds1),
        .status(status1), .done(done1), .lap_min(lap_min1), .lap_sec(lap_sec1),
        .lap_valid(lap_valid1), .lap_count(lap_count1), .lap_ovf(lap_ovf1)
    );

    stopwatch_lap_timer #(.TICK_DIV(4), .MAX_MIN(MAX_MIN), .LAP_DEPTH(DEPTH)) u_td4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
        .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
        .lap(lap), .lap_rd(lap_rd), .minutes(minutes4), .seconds(seconds4),
        .status(status4), .done(done4), .lap_min(lap_min4), .lap_sec(lap_sec4),
        .lap_valid(lap_valid4), .lap_count(lap_count4), .lap_ovf(lap_ovf4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelClear(input int k);
        m_st[k]   = 0;
        m_t[k]    = 0;
        m_pr[k]   = 0;
        m_mode[k] = 0;
        m_done[k] = 0;
        m_cnt[k]  = 0;
        m_ovf[k]  = 0;
        for (int i = 0; i < DEPTH; i++) m_fifo[k][i] = 0;
    endtask

    task automatic modelStep(input int k);
        int  span, snap, lm, ls;
        bit  push, pop, go;
        span = (MAX_MIN + 1) * 60;
        snap = m_t[k];
        push = lap && ((m_st[k] == 1) || (m_st[k] == 2));
        pop  = lap_rd && (m_cnt[k] > 0);
        go   = start && !stop && !(mode_down && (m_t[k] == 0));
        m_done[k] = 0;
        if (reset) begin
            modelClear(k);
            return;
        end
        case (m_st[k])
            0: begin
                if (load) begin
                    lm = int'(load_min);
                    ls = int'(load_sec);
                    if (lm > MAX_MIN) lm = MAX_MIN;
                    if (ls > 59) ls = 59;
                    m_t[k] = lm * 60 + ls;
                end
                if (go) begin
                    m_st[k]   = 1;
                    m_mode[k] = mode_down ? 1 : 0;
                    m_pr[k]   = 0;
                end
            end
            1: begin
                if (stop) begin
                    m_st[k] = 2;
                end else if (m_pr[k] == td[k] - 1) begin
                    m_pr[k] = 0;
                    if (m_mode[k] == 0) begin
                        m_t[k] = (m_t[k] + 1) % span;
                    end else begin
                        m_t[k] = m_t[k] - 1;
                        if (m_t[k] == 0) begin
                            m_st[k]   = 3;
                            m_done[k] = 1;
                        end
                    end
                end else begin
                    m_pr[k] = m_pr[k] + 1;
                end
            end
            2: if (start && !stop) m_st[k] = 1;
            default: ;
        endcase
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) m_fifo[k][i] = m_fifo[k][i + 1];
            m_cnt[k] = m_cnt[k] - 1;
        end
        if (push) begin
            if (m_cnt[k] < DEPTH) begin
                m_fifo[k][m_cnt[k]] = snap;
                m_cnt[k] = m_cnt[k] + 1;
            end else begin
                m_ovf[k] = 1;
            end
        end
    endtask

    task automatic compareAll();
        for (int k = 0; k < 2; k++) begin
            int    mm, ss, st, dn, lmn, lsc, lv, lc, lo, head;
            string nm;
            if (k == 0) begin
                nm = "td1"; mm = int'(minutes1); ss = int'(seconds1); st = int'(status1);
                dn = int'(done1); lmn = int'(lap_min1); lsc = int'(lap_sec1);
                lv = int'(lap_valid1); lc = int'(lap_count1); lo = int'(lap_ovf1);
            end else begin
                nm = "td4"; mm = int'(minutes4); ss = int'(seconds4); st = int'(status4);
                dn = int'(done4); lmn = int'(lap_min4); lsc = int'(lap_sec4);
                lv = int'(lap_valid4); lc = int'(lap_count4); lo = int'(lap_ovf4);
            end
            head = (m_cnt[k] > 0) ? m_fifo[k][0] : 0;
            checkOutput({nm, ".minutes"}, mm, m_t[k] / 60);
            checkOutput({nm, ".seconds"}, ss, m_t[k] % 60);
            checkOutput({nm, ".status"}, st, m_st[k]);
            checkOutput({nm, ".done"}, dn, m_done[k]);
            checkOutput({nm, ".lap_min"}, lmn, head / 60);
            checkOutput({nm, ".lap_sec"}, lsc, head % 60);
            checkOutput({nm, ".lap_valid"}, lv, (m_cnt[k] > 0) ? 1 : 0);
            checkOutput({nm, ".lap_count"}, lc, m_cnt[k]);
            checkOutput({nm, ".lap_ovf"}, lo, m_ovf[k]);
        end
        if (done1) done1_pulses++;
    endtask

    task automatic applyStimulus(input bit st, input bit sp, input bit rs, input bit md,
                                 input bit ld, input int lmin, input int lsec,
                                 input bit lp, input bit rd);
        start     = st;
        stop      = sp;
        reset     = rs;
        mode_down = md;
        load      = ld;
        load_min  = 8'(lmin);
        load_sec  = 6'(lsec);
        lap       = lp;
        lap_rd    = rd;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; reset = 0; mode_down = 0; load = 0; lap = 0; lap_rd = 0;
        load_min = '0; load_sec = '0;
        modelClear(0);
        modelClear(1);
        #12;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Count up for 125 cycles, then pause and confirm the time is frozen.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycles(125);
        checkOutput("run125.min1", int'(minutes1), 2);
        checkOutput("run125.sec1", int'(seconds1), 5);
        checkOutput("run125.sec4", int'(seconds4), 31);
        checkOutput("run125.status1", int'(status1), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stop.status1", int'(status1), 2);
        idleCycles(10);
        checkOutput("frozen.min1", int'(minutes1), 2);
        checkOutput("frozen.sec1", int'(seconds1), 5);

        // Count down from a 00:03 preload to a single done pulse; start afterwards ignored.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 3, 0, 0);
        done1_pulses = 0;
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);
        idleCycles(6);
        checkOutput("down.status1", int'(status1), 3);
        checkOutput("down.done_pulses1", done1_pulses, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("done.start_ignored", int'(status1), 3);
        idleCycles(10);

        // Clamped preload, then wrap from 99:59 to 00:00 while still running.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 200, 61, 0, 0);
        checkOutput("clamp.min1", int'(minutes1), 99);
        checkOutput("clamp.sec1", int'(seconds1), 59);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycles(1);
        checkOutput("wrap.min1", int'(minutes1), 0);
        checkOutput("wrap.sec1", int'(seconds1), 0);
        checkOutput("wrap.status1", int'(status1), 1);

        // Five laps into a four-entry FIFO, then drain in order.
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycles(1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("laps.count1", int'(lap_count1), 4);
        checkOutput("laps.ovf1", int'(lap_ovf1), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("pop.head_sec1", int'(lap_sec1), i);
            checkOutput("pop.head_min1", int'(lap_min1), 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        checkOutput("drained.valid1", int'(lap_valid1), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("empty_pop.count1", int'(lap_count1), 0);

        // Push+pop on a full FIFO keeps the count, then reset clears everything.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("pushpop.count1", int'(lap_count1), 4);
        checkOutput("pushpop.ovf1", int'(lap_ovf1), 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 1, 1);
        checkOutput("reset.valid1", int'(lap_valid1), 0);
        checkOutput("reset.status1", int'(status1), 0);
        checkOutput("reset.ovf1", int'(lap_ovf1), 0);
        checkOutput("reset.sec1", int'(seconds1), 0);

        // Prescaler phase survives a pause on the divide-by-4 instance.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycles(6);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idleCycles(4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idleCycles(1);
        checkOutput("phase.sec4_a", int'(seconds4), 1);
        idleCycles(1);
        checkOutput("phase.sec4_b", int'(seconds4), 2);

        // Asynchronous reset mid-run clears at once.
        idleCycles(3);
        #3;
        rst_n = 1'b0;
        #1;
        modelClear(0);
        modelClear(1);
        compareAll();
        checkOutput("arst.status4", int'(status4), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with occasional reset commands.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0, int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 63)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
